// File: rtl/fpcs_pkg.sv
// rtl/fpcs_pkg.sv - shared state encoding, default widths and saturation constant for fp_convert_sched
package fpcs_pkg;

  localparam int DW_DEF = 12;
  localparam int EW_DEF = 3;
  localparam int FW_DEF = 4;

  localparam logic [11:0] SAT_MAG = 12'h7FF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_convert_sched_if.sv
// rtl/fp_convert_sched_if.sv - request/result bundle between two requesters, consumer and fp_convert_sched
interface fp_convert_sched_if #(
  parameter int DW = fpcs_pkg::DW_DEF,
  parameter int EW = fpcs_pkg::EW_DEF,
  parameter int FW = fpcs_pkg::FW_DEF
);

  logic          req0;
  logic          req1;
  logic [DW-1:0] din0;
  logic [DW-1:0] din1;
  logic [1:0]    gnt;
  logic          busy;
  logic          out_valid;
  logic          out_id;
  logic          out_s;
  logic [EW-1:0] out_e;
  logic [FW-1:0] out_f;
  logic          out_ready;

  modport master (
    output req0, req1, din0, din1, out_ready,
    input  gnt, busy, out_valid, out_id, out_s, out_e, out_f
  );

  modport slave (
    input  req0, req1, din0, din1, out_ready,
    output gnt, busy, out_valid, out_id, out_s, out_e, out_f
  );

endinterface

// File: rtl/mag_extract.sv
// rtl/mag_extract.sv - combinational two's-complement to sign/magnitude split; the most negative input saturates
module mag_extract #(
  parameter int DW = fpcs_pkg::DW_DEF
) (
  input  logic [DW-1:0] din,
  output logic          sign,
  output logic [DW-2:0] mag
);
  import fpcs_pkg::*;

  localparam int MW = DW - 1;
  localparam logic [MW-1:0] SAT = (DW == 12) ? MW'(SAT_MAG) : {MW{1'b1}};

  always_comb begin
    sign = din[DW-1];
    if (din == {1'b1, {MW{1'b0}}}) begin
      mag = SAT;
    end else if (din[DW-1]) begin
      // Low bits suffice: |din| = 2^MW - din[MW-1:0] fits MW bits once the minimum is excluded.
      mag = ~din[MW-1:0] + 1'b1;
    end else begin
      mag = din[MW-1:0];
    end
  end

endmodule

// File: rtl/fp_convert_sched.sv
// rtl/fp_convert_sched.sv - round-robin two-requester integer-to-minifloat converter; FPCS_ROUND_EN enables half-up rounding
module fp_convert_sched #(
  parameter int DW = fpcs_pkg::DW_DEF,
  parameter int EW = fpcs_pkg::EW_DEF,
  parameter int FW = fpcs_pkg::FW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_convert_sched_if.slave     bus
);
  import fpcs_pkg::*;

  localparam int MW = DW - 1;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [MW-1:0] mag_q, mag_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          id_q, id_d;
  logic          sign_q, sign_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic          out_id_q, out_id_d;
  logic          out_s_q, out_s_d;
  logic [EW-1:0] out_e_q, out_e_d;
  logic [FW-1:0] out_f_q, out_f_d;

  logic          sel1;
  logic [DW-1:0] din_sel;
  logic          cap_sign;
  logic [MW-1:0] cap_mag;
  logic [FW-1:0] f_trunc;

  // prio_q high means requester 1 wins a tie.
  assign sel1    = bus.req1 & (~bus.req0 | prio_q);
  assign din_sel = sel1 ? bus.din1 : bus.din0;
  assign f_trunc = mag_q[MW-1 -: FW];

`ifdef FPCS_ROUND_EN
  logic rbit;
  assign rbit = mag_q[MW-1-FW];
`endif

  mag_extract #(.DW(DW)) u_mag_extract (
    .din  (din_sel),
    .sign (cap_sign),
    .mag  (cap_mag)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    id_d        = id_q;
    sign_d      = sign_q;
    gnt_d       = 2'b00;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_s_d     = out_s_q;
    out_e_d     = out_e_q;
    out_f_d     = out_f_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          id_d    = sel1;
          sign_d  = cap_sign;
          mag_d   = cap_mag;
          exp_d   = '1;
          gnt_d   = sel1 ? 2'b10 : 2'b01;
          prio_d  = ~sel1;
          busy_d  = 1'b1;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q[MW-1] || exp_q == '0) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 1'b1;
        end
      end
      S_ROUND: begin
        out_id_d    = id_q;
        out_s_d     = sign_q;
`ifdef FPCS_ROUND_EN
        if (rbit && f_trunc == '1) begin
          if (exp_q == '1) begin
            out_e_d = '1;
            out_f_d = '1;
          end else begin
            out_e_d = exp_q + 1'b1;
            out_f_d = {1'b1, {(FW-1){1'b0}}};
          end
        end else begin
          out_e_d = exp_q;
          out_f_d = f_trunc + FW'(rbit);
        end
`else
        out_e_d     = exp_q;
        out_f_d     = f_trunc;
`endif
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      id_q        <= 1'b0;
      sign_q      <= 1'b0;
      gnt_q       <= 2'b00;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_f_q     <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      id_q        <= id_d;
      sign_q      <= sign_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_s_q     <= out_s_d;
      out_e_q     <= out_e_d;
      out_f_q     <= out_f_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_e     = out_e_q;
  assign bus.out_f     = out_f_q;

endmodule

// File: tb/tb_fp_convert_sched.sv
// tb/tb_fp_convert_sched.sv - scoreboard bench for fp_convert_sched with directed vectors
module tb_fp_convert_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_convert_sched_if #(.DW(12), .EW(3), .FW(4)) bus ();

  fp_convert_sched #(.DW(12), .EW(3), .FW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef FPCS_ROUND_EN
  localparam int E124 = 4, F124 = 8, F1344 = 11;
`else
  localparam int E124 = 3, F124 = 15, F1344 = 10;
`endif

  typedef struct {
    int id;
    int s;
    int e;
    int f;
    int lat;
    int cap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (bus.out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=1 required=0");
      end else begin
        x = sb.pop_front();
        check("out_id", int'(bus.out_id), x.id);
        check("out_s", int'(bus.out_s), x.s);
        check("out_e", int'(bus.out_e), x.e);
        check("out_f", int'(bus.out_f), x.f);
        check("latency", cyc - x.cap, x.lat);
      end
    end
    prev_v = bus.out_valid;
  end

  task automatic wait_gnt(output int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == 2'b00 && n < 30);
    g = int'(bus.gnt);
    if (bus.gnt == 2'b00) check("gnt_timeout", 0, 1);
  endtask

  task automatic push(input int id, input int s, input int e, input int f, input int lat);
    exp_t x;
    x.id = id; x.s = s; x.e = e; x.f = f; x.lat = lat; x.cap = cyc;
    sb.push_back(x);
  endtask

  task automatic issue(input int which, input logic [11:0] d,
                       input int s, input int e, input int f, input int lat);
    int g;
    if (which == 0) begin bus.din0 = d; bus.req0 = 1'b1; end
    else            begin bus.din1 = d; bus.req1 = 1'b1; end
    wait_gnt(g);
    check("gnt", g, (which == 0) ? 1 : 2);
    if (g != 0) push(which, s, e, f, lat);
    if (which == 0) bus.req0 = 1'b0;
    else            bus.req1 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || bus.out_valid) check("idle_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, int'(bus.gnt), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_valid"}, int'(bus.out_valid), 0);
    check({tag, "_id"}, int'(bus.out_id), 0);
    check({tag, "_s"}, int'(bus.out_s), 0);
    check({tag, "_e"}, int'(bus.out_e), 0);
    check({tag, "_f"}, int'(bus.out_f), 0);
  endtask

  initial begin
    int g;
    int n;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 12'h000, 0, 0, 0, 9);      wait_idle();
    issue(0, 12'h800, 1, 7, 15, 2);     wait_idle();
    issue(1, 12'd422, 0, 5, 13, 4);     wait_idle();
    issue(0, 12'd124, 0, E124, F124, 6); wait_idle();
    issue(1, 12'h7FF, 0, 7, 15, 2);     wait_idle();
    issue(0, 12'hE5A, 1, 5, 13, 4);     wait_idle();
    issue(0, 12'd1344, 0, 7, F1344, 2); wait_idle();

    // Tie after reset with a stalled consumer.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.din0 = 12'd422;
    bus.din1 = 12'd124;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    wait_gnt(g);
    check("tie_gnt0", g, 1);
    push(0, 0, 5, 13, 4);
    bus.req0 = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    check("tie_valid", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_gnt", int'(bus.gnt), 0);
      check("hold_id", int'(bus.out_id), 0);
      check("hold_e", int'(bus.out_e), 5);
      check("hold_f", int'(bus.out_f), 13);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", int'(bus.out_valid), 0);
    check("release_busy", int'(bus.busy), 0);
    check("release_gnt", int'(bus.gnt), 0);
    @(negedge clk);
    check("tie_gnt1", int'(bus.gnt), 2);
    if (bus.gnt == 2'b10) push(1, 0, E124, F124, 6);
    bus.req1 = 1'b0;
    wait_idle();

    // Reset during NORM, then tie again: req0 must be favoured.
    bus.din0 = 12'h000;
    bus.req0 = 1'b1;
    wait_gnt(g);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.din1 = 12'd422;
    bus.req1 = 1'b1;
    issue(0, 12'hFFF, 1, 0, 1, 9);
    issue(1, 12'd422, 0, 5, 13, 4);
    wait_idle();

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (sb.size() != 0) check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
